// File: rtl/axi_master_arbiter.sv
// Two-requester round-robin arbiter that sequences single-beat AXI-style read/write
// transactions to one shared slave and acknowledges the owning requester.
module axi_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // Requester 0
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m0_resp,
  // Requester 1
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [DATA_WIDTH-1:0] m1_resp,
  // Status
  output logic                  busy,
  output logic                  owner,
  // Write address / data / response channels
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  write_valid,
  input  logic                  write_ready,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_data_valid,
  input  logic                  write_data_ready,
  input  logic [DATA_WIDTH-1:0] write_response,
  input  logic                  write_response_valid,
  output logic                  write_response_ready,
  // Read address / data / response channels
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  read_valid,
  input  logic                  read_ready,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic [DATA_WIDTH-1:0] read_response,
  input  logic                  read_response_valid,
  output logic                  read_response_ready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_valid_q;
  logic                  write_data_valid_q;
  logic                  write_response_ready_q;
  logic                  read_valid_q;
  logic                  read_response_ready_q;
  logic                  m0_ack_q;
  logic                  m1_ack_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q;
  logic [DATA_WIDTH-1:0] m1_rdata_q;
  logic [DATA_WIDTH-1:0] m0_resp_q;
  logic [DATA_WIDTH-1:0] m1_resp_q;

  logic                  any_req;
  logic                  grant_sel;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  aw_done;
  logic                  w_done;

  // On a tie, the requester that did not win last time is granted.
  assign any_req   = m0_req | m1_req;
  assign grant_sel = (m0_req & m1_req) ? ~last_grant_q : m1_req;
  assign sel_write = grant_sel ? m1_write : m0_write;
  assign sel_addr  = grant_sel ? m1_addr  : m0_addr;
  assign sel_wdata = grant_sel ? m1_wdata : m0_wdata;

  // A write channel is finished once its valid has dropped or it is handshaking now.
  assign aw_done = ~write_valid_q | write_ready;
  assign w_done  = ~write_data_valid_q | write_data_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q                <= StIdle;
      last_grant_q           <= 1'b1;
      owner_q                <= 1'b0;
      addr_q                 <= '0;
      wdata_q                <= '0;
      write_valid_q          <= 1'b0;
      write_data_valid_q     <= 1'b0;
      write_response_ready_q <= 1'b0;
      read_valid_q           <= 1'b0;
      read_response_ready_q  <= 1'b0;
      m0_ack_q               <= 1'b0;
      m1_ack_q               <= 1'b0;
      m0_rdata_q             <= '0;
      m1_rdata_q             <= '0;
      m0_resp_q              <= '0;
      m1_resp_q              <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q      <= grant_sel;
            last_grant_q <= grant_sel;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            if (sel_write) begin
              write_valid_q      <= 1'b1;
              write_data_valid_q <= 1'b1;
              state_q            <= StWrReq;
            end else begin
              read_valid_q <= 1'b1;
              state_q      <= StRdReq;
            end
          end
        end
        StWrReq: begin
          if (write_ready) begin
            write_valid_q <= 1'b0;
          end
          if (write_data_ready) begin
            write_data_valid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            write_response_ready_q <= 1'b1;
            state_q                <= StWrResp;
          end
        end
        StWrResp: begin
          if (write_response_valid) begin
            write_response_ready_q <= 1'b0;
            if (owner_q) begin
              m1_resp_q <= write_response;
              m1_ack_q  <= 1'b1;
            end else begin
              m0_resp_q <= write_response;
              m0_ack_q  <= 1'b1;
            end
            state_q <= StDone;
          end
        end
        StRdReq: begin
          if (read_ready) begin
            read_valid_q          <= 1'b0;
            read_response_ready_q <= 1'b1;
            state_q               <= StRdResp;
          end
        end
        StRdResp: begin
          if (read_response_valid) begin
            read_response_ready_q <= 1'b0;
            if (owner_q) begin
              m1_rdata_q <= read_data;
              m1_resp_q  <= read_response;
              m1_ack_q   <= 1'b1;
            end else begin
              m0_rdata_q <= read_data;
              m0_resp_q  <= read_response;
              m0_ack_q   <= 1'b1;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy                 = (state_q != StIdle);
  assign owner                = owner_q;
  assign write_address        = addr_q;
  assign read_address         = addr_q;
  assign write_data           = wdata_q;
  assign write_valid          = write_valid_q;
  assign write_data_valid     = write_data_valid_q;
  assign write_response_ready = write_response_ready_q;
  assign read_valid           = read_valid_q;
  assign read_response_ready  = read_response_ready_q;
  assign m0_ack               = m0_ack_q;
  assign m1_ack               = m1_ack_q;
  assign m0_rdata             = m0_rdata_q;
  assign m1_rdata             = m1_rdata_q;
  assign m0_resp              = m0_resp_q;
  assign m1_resp              = m1_resp_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: the slave side is driven by hand, and outputs
// are sampled 1ns after each rising edge.
module tb_axi_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clock;
  logic          reset_n;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata, m0_resp, m1_resp;
  logic          busy, owner;
  logic [AW-1:0] write_address, read_address;
  logic          write_valid, write_ready, write_data_valid, write_data_ready;
  logic [DW-1:0] write_data, write_response, read_data, read_response;
  logic          write_response_valid, write_response_ready;
  logic          read_valid, read_ready, read_response_valid, read_response_ready;

  int tests;
  int fails;

  axi_master_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .m0_req               (m0_req),
    .m0_write             (m0_write),
    .m0_addr              (m0_addr),
    .m0_wdata             (m0_wdata),
    .m0_ack               (m0_ack),
    .m0_rdata             (m0_rdata),
    .m0_resp              (m0_resp),
    .m1_req               (m1_req),
    .m1_write             (m1_write),
    .m1_addr              (m1_addr),
    .m1_wdata             (m1_wdata),
    .m1_ack               (m1_ack),
    .m1_rdata             (m1_rdata),
    .m1_resp              (m1_resp),
    .busy                 (busy),
    .owner                (owner),
    .write_address        (write_address),
    .write_valid          (write_valid),
    .write_ready          (write_ready),
    .write_data           (write_data),
    .write_data_valid     (write_data_valid),
    .write_data_ready     (write_data_ready),
    .write_response       (write_response),
    .write_response_valid (write_response_valid),
    .write_response_ready (write_response_ready),
    .read_address         (read_address),
    .read_valid           (read_valid),
    .read_ready           (read_ready),
    .read_data            (read_data),
    .read_response        (read_response),
    .read_response_valid  (read_response_valid),
    .read_response_ready  (read_response_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    write_ready = 0; write_data_ready = 0; write_response = '0; write_response_valid = 0;
    read_ready = 0; read_data = '0; read_response = '0; read_response_valid = 0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_wvalid", write_valid, 0);
    check("rst_rvalid", read_valid, 0);
    check("rst_waddr", write_address, 0);
    reset_n = 1'b1;
    tick();

    // Single write from m0, slave immediately ready, response 0.
    write_ready = 1; write_data_ready = 1; write_response_valid = 1; write_response = 0;
    m0_req = 1; m0_write = 1; m0_addr = 10; m0_wdata = 1234;
    tick();
    check("wr_wvalid", write_valid, 1);
    check("wr_wdvalid", write_data_valid, 1);
    check("wr_waddr", write_address, 10);
    check("wr_wdata", write_data, 1234);
    check("wr_busy", busy, 1);
    check("wr_owner", owner, 0);
    check("wr_ack_c1", m0_ack, 0);
    tick();
    check("wr_wvalid_drop", write_valid, 0);
    check("wr_wdvalid_drop", write_data_valid, 0);
    check("wr_bready", write_response_ready, 1);
    check("wr_ack_c2", m0_ack, 0);
    tick();
    check("wr_ack", m0_ack, 1);
    check("wr_m1_ack", m1_ack, 0);
    check("wr_resp", m0_resp, 0);
    check("wr_bready_drop", write_response_ready, 0);
    tick();
    m0_req = 0;
    check("wr_ack_end", m0_ack, 0);
    check("wr_idle", busy, 0);
    write_response_valid = 0;
    tick();

    // Single read from m1 with a 4-cycle response delay.
    read_ready = 1; read_response_valid = 0;
    m1_req = 1; m1_write = 0; m1_addr = 10;
    tick();
    check("rd_rvalid", read_valid, 1);
    check("rd_raddr", read_address, 10);
    check("rd_owner0", owner, 1);
    tick();
    check("rd_rvalid_drop", read_valid, 0);
    check("rd_rready", read_response_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_wait_ack", m1_ack, 0);
      check("rd_wait_owner", owner, 1);
      check("rd_wait_busy", busy, 1);
    end
    read_data = 1234; read_response = 7; read_response_valid = 1;
    tick();
    check("rd_ack", m1_ack, 1);
    check("rd_rdata", m1_rdata, 1234);
    check("rd_resp", m1_resp, 7);
    check("rd_owner1", owner, 1);
    read_response_valid = 0;
    tick();
    m1_req = 0;
    check("rd_ack_end", m1_ack, 0);
    tick();

    // Simultaneous requests from reset: m0 first, then m1, then m0 again.
    reset_n = 0;
    #1;
    reset_n = 1;
    write_ready = 1; write_data_ready = 1; write_response_valid = 1; write_response = 3;
    read_ready = 1; read_response_valid = 1; read_data = 32'hab; read_response = 0;
    m0_req = 1; m0_write = 1; m0_addr = 20; m0_wdata = 32'h55;
    m1_req = 1; m1_write = 0; m1_addr = 30;
    tick();
    check("tie1_owner", owner, 0);
    check("tie1_wvalid", write_valid, 1);
    check("tie1_rvalid", read_valid, 0);
    tick();
    tick();
    check("tie1_m0_ack", m0_ack, 1);
    check("tie1_m1_ack", m1_ack, 0);
    check("tie1_m0_resp", m0_resp, 3);
    tick();
    m0_req = 0;
    tick();
    check("tie1_owner_m1", owner, 1);
    check("tie1_raddr", read_address, 30);
    tick();
    tick();
    check("tie1_m1_ack2", m1_ack, 1);
    check("tie1_m1_rdata", m1_rdata, 32'hab);
    tick();
    m0_req = 1; m0_write = 0; m0_addr = 24;
    tick();
    check("tie2_owner", owner, 0);
    tick();
    tick();
    check("tie2_m0_ack", m0_ack, 1);
    check("tie2_m0_rdata", m0_rdata, 32'hab);
    tick();
    m0_req = 0;
    tick();
    check("tie2_owner_m1", owner, 1);
    tick();
    tick();
    check("tie2_m1_ack", m1_ack, 1);
    tick();
    m1_req = 0;
    write_response_valid = 0; read_response_valid = 0;
    tick();

    // Skewed write: address ready first, data ready three cycles later.
    write_ready = 1; write_data_ready = 0; write_response = 9;
    m0_req = 1; m0_write = 1; m0_addr = 40; m0_wdata = 32'h77;
    tick();
    check("sk1_wvalid", write_valid, 1);
    check("sk1_wdvalid", write_data_valid, 1);
    tick();
    check("sk1_wvalid_drop", write_valid, 0);
    check("sk1_wdvalid_hold", write_data_valid, 1);
    tick();
    tick();
    check("sk1_wdvalid_hold2", write_data_valid, 1);
    check("sk1_no_bready", write_response_ready, 0);
    check("sk1_wdata_stable", write_data, 32'h77);
    write_data_ready = 1;
    tick();
    check("sk1_wdvalid_drop", write_data_valid, 0);
    check("sk1_bready", write_response_ready, 1);
    write_response_valid = 1;
    tick();
    check("sk1_ack", m0_ack, 1);
    check("sk1_resp", m0_resp, 9);
    write_response_valid = 0;
    tick();
    m0_req = 0;

    // Reverse skew from m1: data ready first, address ready three cycles later.
    write_ready = 0; write_data_ready = 1; write_response = 4;
    m1_req = 1; m1_write = 1; m1_addr = 50; m1_wdata = 32'h88;
    tick();
    check("sk2_owner", owner, 1);
    check("sk2_wvalid", write_valid, 1);
    tick();
    check("sk2_wdvalid_drop", write_data_valid, 0);
    check("sk2_wvalid_hold", write_valid, 1);
    tick();
    tick();
    check("sk2_wvalid_hold2", write_valid, 1);
    check("sk2_waddr_stable", write_address, 50);
    check("sk2_no_bready", write_response_ready, 0);
    write_ready = 1;
    tick();
    check("sk2_wvalid_drop", write_valid, 0);
    check("sk2_bready", write_response_ready, 1);
    write_response_valid = 1;
    tick();
    check("sk2_ack", m1_ack, 1);
    check("sk2_resp", m1_resp, 4);
    check("sk2_rdata_hold", m1_rdata, 32'hab);
    write_response_valid = 0;
    tick();
    m1_req = 0;
    tick();

    // Address change after grant, then reset in the response phase.
    read_ready = 0; read_response_valid = 0;
    m1_req = 1; m1_write = 0; m1_addr = 60;
    tick();
    m1_addr = 99;
    tick();
    check("chg_raddr", read_address, 60);
    check("chg_rvalid", read_valid, 1);
    read_ready = 1;
    tick();
    check("chg_rready", read_response_ready, 1);
    check("chg_owner", owner, 1);
    reset_n = 0;
    #1;
    check("mrst_rready", read_response_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_owner", owner, 0);
    check("mrst_raddr", read_address, 0);
    check("mrst_m1_rdata", m1_rdata, 0);
    check("mrst_m1_resp", m1_resp, 0);
    m1_req = 0;
    read_data = 32'hdead; read_response_valid = 1;
    tick();
    reset_n = 1;
    tick();
    check("mrst_no_ack1", m1_ack, 0);
    tick();
    check("mrst_no_ack2", m1_ack, 0);
    check("mrst_idle", busy, 0);
    read_response_valid = 0;
    m0_req = 1; m0_write = 0; m0_addr = 70;
    m1_req = 1; m1_write = 0; m1_addr = 80;
    tick();
    check("mrst_tie_owner", owner, 0);
    check("mrst_tie_raddr", read_address, 70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
